// File: rtl/load_store_unit.sv
// Load/store initiator for a word-addressed data memory with combinational ReadData.
// Handles sub-word loads with extension, sub-word stores as read-modify-write, and fault reporting.
module load_store_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_fault;

  logic        w_accept;
  logic        w_fault;
  logic        w_range_bad;
  logic [31:0] w_lane_shift;
  logic [31:0] w_load_data;
  logic [31:0] w_mask;
  logic [31:0] w_merged;
  logic [31:0] w_word_addr;

  assign req_ready   = (r_state == IDLE) & ~reset;
  assign resp_valid  = (r_state == RESP) & ~reset;
  assign resp_rdata  = r_rdata;
  assign resp_fault  = r_fault;
  assign w_accept    = req_valid & req_ready;
  assign w_word_addr = {r_addr[31:2], 2'b00};

  assign w_range_bad = (req_addr >> ADDR_BITS) != '0;
  assign w_fault = (req_size == 2'b11) | w_range_bad |
                   ((req_size == 2'b01) & req_addr[0]) |
                   ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

  // Aligned sub-word accesses share one shift: a half always sits at byte offset 0 or 2.
  assign w_lane_shift = ReadData >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_data = ReadData;
    case (r_size)
      2'b00:   w_load_data = {{24{~r_unsigned & w_lane_shift[7]}},  w_lane_shift[7:0]};
      2'b01:   w_load_data = {{16{~r_unsigned & w_lane_shift[15]}}, w_lane_shift[15:0]};
      default: w_load_data = ReadData;
    endcase
  end

  assign w_mask   = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {r_addr[1:0], 3'b000};
  assign w_merged = (r_word & ~w_mask) | ((r_wdata << {r_addr[1:0], 3'b000}) & w_mask);

  always_comb begin
    w_next    = r_state;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_fault)                 w_next = RESP;
          else if (!req_write)         w_next = LOAD;
          else if (req_size == 2'b10)  w_next = STORE;
          else                         w_next = RMW_RD;
        end
      end
      LOAD: begin
        MemRead = 1'b1;
        Address = w_word_addr;
        w_next  = RESP;
      end
      STORE: begin
        MemWrite  = 1'b1;
        Address   = w_word_addr;
        WriteData = r_wdata;
        w_next    = RESP;
      end
      RMW_RD: begin
        MemRead = 1'b1;
        Address = w_word_addr;
        w_next  = RMW_WR;
      end
      RMW_WR: begin
        MemWrite  = 1'b1;
        Address   = w_word_addr;
        WriteData = w_merged;
        w_next    = RESP;
      end
      RESP: begin
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset must abort any in-flight access combinationally, not just at the next edge.
    if (reset) begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_word     <= '0;
      r_rdata    <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_fault    <= w_fault;
        r_rdata    <= '0;
      end
      if (r_state == LOAD)   r_rdata <= w_load_data;
      if (r_state == RMW_RD) r_word  <= ReadData;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a bench-side data memory and a reference model
// that predicts responses, memory traffic and latency from the request alone.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic        exp_fault;
  int          exp_rd, exp_wr, exp_lat;
  int          nrd, nwr;
  logic        txn_on = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_BITS(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  assign ReadData = mem[Address[9:2]];
  always @(posedge clk) if (MemWrite) mem[Address[9:2]] <= WriteData;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: outcome of a request against ref_mem, which it also updates for stores.
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] word, v, nw;
    int off, nb;
    exp_fault = (sz == 2'd3) || (a[31:10] != 0) || (sz == 2'd1 && a[0]) ||
                (sz == 2'd2 && a[1:0] != 0);
    exp_addr  = {a[31:2], 2'b00};
    exp_rdata = 0; exp_wdata = 0; exp_rd = 0; exp_wr = 0;
    exp_lat   = 1;
    if (!exp_fault) begin
      word = ref_mem[a[9:2]];
      off  = int'(a[1:0]);
      nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if (!w) begin
        exp_rd = 1; exp_lat = 2;
        v = 0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = word[8*(off+k) +: 8];
        if (!u && nb < 4 && v[8*nb-1])
          for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
        exp_rdata = v;
      end else begin
        exp_wr = 1;
        nw = word;
        for (int k = 0; k < nb; k++) nw[8*(off+k) +: 8] = wd[8*k +: 8];
        if (nb == 4) exp_lat = 2;
        else begin exp_rd = 1; exp_lat = 3; end
        exp_wdata = nw;
        ref_mem[a[9:2]] = nw;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("memwrite_in_reset", {31'b0, MemWrite}, 32'd0);
    end else if (txn_on) begin
      if (MemRead)  nrd++;
      if (MemWrite) nwr++;
      if (exp_fault) chk("fault_no_mem", {30'b0, MemRead, MemWrite}, 32'd0);
      if (MemRead | MemWrite) chk("mem_addr", Address, exp_addr);
      if (MemWrite) chk("mem_wdata", WriteData, exp_wdata);
      if (resp_valid) begin
        chk("model_rdata", resp_rdata, exp_rdata);
        chk("model_fault", {31'b0, resp_fault}, {31'b0, exp_fault});
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] lit, input logic litf, input int hold);
    int cyc;
    model(w, sz, u, a, wd);
    @(negedge clk);
    nrd = 0; nwr = 0; txn_on = 1'b1;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!resp_valid && cyc < 20);
    chk("latency", cyc, exp_lat);
    chk("lit_rdata", resp_rdata, lit);
    chk("lit_fault", {31'b0, resp_fault}, {31'b0, litf});
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h10;
      @(negedge clk);
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, lit);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("valid_cleared", {31'b0, resp_valid}, 32'd0);
    chk("ready_back", {31'b0, req_ready}, 32'd1);
    chk("n_reads", nrd, exp_rd);
    chk("n_writes", nwr, exp_wr);
    txn_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    mem[0] = 10; mem[1] = 1; mem[4] = 100;
    ref_mem[0] = 10; ref_mem[1] = 1; ref_mem[4] = 100;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 0; req_wdata = 0; resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_ctl", {30'b0, MemRead, MemWrite}, 32'd0);
    chk("rst_address", Address, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    //     w     sz     u     addr          wdata          literal        flt   hold
    do_req(1'b0, 2'd2, 1'b0, 32'h00,       32'h0,         32'd10,        1'b0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10,       32'h0,         32'd100,       1'b0, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h05,       32'h000000AB,  32'h0,         1'b0, 0);
    chk("mem1_after_sb", mem[1], 32'h0000AB01);
    do_req(1'b0, 2'd0, 1'b0, 32'h05,       32'h0,         32'hFFFFFFAB,  1'b0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h05,       32'h0,         32'h000000AB,  1'b0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h12,       32'h00001234,  32'h0,         1'b0, 0);
    chk("mem4_after_sh", mem[4], 32'h12340064);
    do_req(1'b0, 2'd1, 1'b0, 32'h12,       32'h0,         32'h00001234,  1'b0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h08,       32'hDEADBEEF,  32'h0,         1'b0, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h0A,       32'h0,         32'h0000DEAD,  1'b0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h03,       32'h0,         32'h0,         1'b1, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h02,       32'h0,         32'h0,         1'b1, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h400,      32'h0,         32'h0,         1'b1, 0);
    do_req(1'b1, 2'd3, 1'b0, 32'h00,       32'h0,         32'h0,         1'b1, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h07,       32'hFFFF,      32'h0,         1'b1, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h00,       32'h0,         32'd10,        1'b0, 5);

    // Reset while the read half of a byte store is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h05; req_wdata = 32'h55;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_active", {31'b0, MemRead}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_fault", {31'b0, resp_fault}, 32'd0);
    chk("abort_mem_ctl", {30'b0, MemRead, MemWrite}, 32'd0);
    chk("abort_address", Address, 32'd0);
    chk("abort_wdata", WriteData, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", {31'b0, req_ready}, 32'd1);
    chk("abort_mem1", mem[1], ref_mem[1]);
    chk("abort_mem1_lit", mem[1], 32'h0000AB01);

    do_req(1'b0, 2'd0, 1'b1, 32'h05,       32'h0,         32'h000000AB,  1'b0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h04,       32'h0,         32'h0000AB01,  1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
